// File: rtl/game_pkg.sv
// Shared types for the game-phase sequencer: overlay selector and FSM state encoding.
package game_pkg;

  typedef enum logic [1:0] {
    SCR_START = 2'd0,
    SCR_PLAY  = 2'd1,
    SCR_WIN   = 2'd2,
    SCR_LOSE  = 2'd3
  } screen_t;

  // State encoding is identical to screen_t so the overlay select is a straight copy.
  typedef enum logic [1:0] {
    StStart = 2'd0,
    StPlay  = 2'd1,
    StWin   = 2'd2,
    StLose  = 2'd3
  } state_t;

  function automatic screen_t state_to_screen(input state_t st);
    return screen_t'(st);
  endfunction

endpackage

// File: rtl/key_edge_detect.sv
// N-bit rising-edge detector; output is a one-cycle pulse per low-to-high transition.
module key_edge_detect #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] hist_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= '0;
    end else begin
      hist_q <= level;
    end
  end

  assign rise = level & ~hist_q;

endmodule

// File: rtl/game_screen_ctrl.sv
// Game-phase sequencer: chooses the full-screen overlay, enables gameplay and
// issues the level-restart pulse.
module game_screen_ctrl
  import game_pkg::*;
#(
  parameter int unsigned KEY_LOCK_FRAMES    = 30,
  parameter int unsigned AUTO_RETURN_FRAMES = 600
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    frame_tick,
  input  logic    key_enter,
  input  logic    key_space,
  input  logic    start_game,
  input  logic    win,
  input  logic    lose,
  output screen_t screen_sel,
  output logic    screen_active,
  output logic    game_run,
  output logic    game_reset
);

  localparam int unsigned CntW = $clog2(AUTO_RETURN_FRAMES + 1);

  state_t          state_q, state_d;
  logic [CntW-1:0] frame_cnt_q, frame_cnt_d;
  logic [2:0]      key_rise;
  logic            req, unlocked, timeout, restart;

  screen_t screen_sel_q, screen_sel_d;
  logic    screen_active_q, screen_active_d;
  logic    game_run_q, game_run_d;
  logic    game_reset_q;

  key_edge_detect #(
    .WIDTH (3)
  ) u_key_edge (
    .clk   (clk),
    .rst   (rst),
    .level ({start_game, key_space, key_enter}),
    .rise  (key_rise)
  );

  assign req      = |key_rise;
  assign unlocked = (KEY_LOCK_FRAMES == 0) || ({1'b0, frame_cnt_q} >= (CntW + 1)'(KEY_LOCK_FRAMES));
  assign timeout  = (frame_cnt_q == CntW'(AUTO_RETURN_FRAMES));

  // A key request beats the timeout because it is tested first in every branch.
  always_comb begin
    state_d = state_q;
    restart = 1'b0;
    case (state_q)
      StStart: begin
        if (req && unlocked) begin
          state_d = StPlay;
          restart = 1'b1;
        end
      end
      StPlay: begin
        if (lose) begin
          state_d = StLose;
        end else if (win) begin
          state_d = StWin;
        end
      end
      StWin: begin
        if ((req && unlocked) || timeout) begin
          state_d = StStart;
        end
      end
      StLose: begin
        if (req && unlocked) begin
          state_d = StPlay;
          restart = 1'b1;
        end else if (timeout) begin
          state_d = StStart;
        end
      end
      default: state_d = StStart;
    endcase
  end

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (state_d != state_q) begin
      frame_cnt_d = '0;
    end else if (frame_tick && !timeout) begin
      frame_cnt_d = frame_cnt_q + 1'b1;
    end
  end

  // Outputs decode the next state so they update on the same edge as the state.
  always_comb begin
    screen_sel_d    = state_to_screen(state_d);
    screen_active_d = (state_d != StPlay);
    game_run_d      = (state_d == StPlay);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= StStart;
      frame_cnt_q     <= '0;
      screen_sel_q    <= SCR_START;
      screen_active_q <= 1'b1;
      game_run_q      <= 1'b0;
      game_reset_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      frame_cnt_q     <= frame_cnt_d;
      screen_sel_q    <= screen_sel_d;
      screen_active_q <= screen_active_d;
      game_run_q      <= game_run_d;
      game_reset_q    <= restart;
    end
  end

  assign screen_sel    = screen_sel_q;
  assign screen_active = screen_active_q;
  assign game_run      = game_run_q;
  assign game_reset    = game_reset_q;

endmodule
